// File: rtl/pb_conditioner.sv
// pb_conditioner: push-button conditioning ahead of the pong game FSM.
// Raw active-low buttons are synchronised and debounced. Each debounced press
// latches a hit request that is held until the game tick consumes it. BOTH
// reports that every button is held.
// Optional feature macro: PB_LOCKOUT_EN (anti-mashing lockout after a consumed hit).
module pb_conditioner #(
   parameter int N             = 2,
   parameter int DB_CYCLES     = 500_000,
   parameter int CNT_W         = 19,
   parameter int LOCKOUT_TICKS = 2,
   parameter int LOCK_W        = 2
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [N-1:0] PB,
   input  logic         TICK,
   output logic [N-1:0] PRESSED,
   output logic [N-1:0] PRESS_PULSE,
   output logic [N-1:0] HIT,
   output logic         BOTH
);

   // Reject parameter sets whose counters cannot hold their terminal values.
   if (DB_CYCLES < 2 || (DB_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_db_cfg
      $error("pb_conditioner: DB_CYCLES must be >= 2 and fit in CNT_W bits");
   end
   if (LOCKOUT_TICKS < 1 || LOCKOUT_TICKS >= (1 << LOCK_W)) begin : g_bad_lock_cfg
      $error("pb_conditioner: LOCKOUT_TICKS must be >= 1 and fit in LOCK_W bits");
   end

   logic [N-1:0] sync1_q;
   logic [N-1:0] sync2_q;
   logic [N-1:0] s;

   // Two-flop synchroniser; resets to the released (high) level.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= PB;
         sync2_q <= sync1_q;
      end
   end

   // Active-high view of the synchronised buttons.
   assign s = ~sync2_q;

   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             db_q;
      logic             db_d;
      logic             pulse_q;
      logic             hit_q;
      logic             hit_d;
      logic             locked;
      logic             hit_set;

      // Debounce: count cycles the input disagrees with the accepted level.
      always_comb begin
         cnt_d = '0;
         db_d  = db_q;
         if (s[gi] != db_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
               db_d = s[gi];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

`ifdef PB_LOCKOUT_EN
      logic [LOCK_W-1:0] lock_q;

      // Lockout: armed when a hit is consumed, counts down on later ticks.
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            lock_q <= '0;
         end else if (hit_q && TICK && !hit_set) begin
            lock_q <= LOCK_W'(LOCKOUT_TICKS);
         end else if (TICK && lock_q != '0) begin
            lock_q <= lock_q - LOCK_W'(1);
         end
      end

      assign locked = (lock_q != '0);
`else
      assign locked = 1'b0;
`endif

      // A press sets the hit unless locked out; a tick clears it, set wins.
      assign hit_set = pulse_q & ~locked;
      assign hit_d   = hit_set | (hit_q & ~TICK);

      // Per-button state: counter, accepted level, press pulse, hit latch.
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            cnt_q   <= '0;
            db_q    <= 1'b0;
            pulse_q <= 1'b0;
            hit_q   <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            pulse_q <= db_d & ~db_q;
            hit_q   <= hit_d;
         end
      end

      assign PRESSED[gi]     = db_q;
      assign PRESS_PULSE[gi] = pulse_q;
      assign HIT[gi]         = hit_q;
   end

   // Start/restart condition: all buttons held, no added latency.
   assign BOTH = &PRESSED;

endmodule

// File: tb/tb_pb_conditioner.sv
// Testbench for pb_conditioner: directed scenarios followed by random button
// and tick activity, checked cycle by cycle against a reference model.
module tb_pb_conditioner;
   localparam int N      = 2;
   localparam int DB     = 4;
   localparam int CNT_W  = 3;
   localparam int LT     = 2;
   localparam int LOCK_W = 2;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [N-1:0] PB  = '1;
   logic         TICK = 1'b0;
   logic [N-1:0] PRESSED;
   logic [N-1:0] PRESS_PULSE;
   logic [N-1:0] HIT;
   logic         BOTH;

   always #5 CLK = ~CLK;

   pb_conditioner #(
      .N(N), .DB_CYCLES(DB), .CNT_W(CNT_W), .LOCKOUT_TICKS(LT), .LOCK_W(LOCK_W)
   ) dut (
      .CLK(CLK), .RST(RST), .PB(PB), .TICK(TICK),
      .PRESSED(PRESSED), .PRESS_PULSE(PRESS_PULSE), .HIT(HIT), .BOTH(BOTH)
   );

   typedef struct packed {
      logic [N-1:0] pressed;
      logic [N-1:0] pulse;
      logic [N-1:0] hit;
      logic         both;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   mon_cyc  = 0;

   // Reference model state
   logic [N-1:0] raw_log[$];   // raw PB per cycle since reset (two released entries pre-seeded)
   logic [N-1:0] s_log[$];     // pressed-view samples seen by the debouncer
   int           flip_t[N];    // s_log index where each bit last changed level
   logic [N-1:0] m_pressed, m_pulse, m_hit;
   bit           consumed[N];
   int           ticks_after[N];

   function automatic void model_reset();
      raw_log.delete();
      raw_log.push_back('1);
      raw_log.push_back('1);
      s_log.delete();
      for (int i = 0; i < N; i++) begin
         flip_t[i] = 0;
         consumed[i] = 1'b0;
         ticks_after[i] = 0;
      end
      m_pressed = '0;
      m_pulse   = '0;
      m_hit     = '0;
   endfunction

   // Predict the outputs visible after the coming clock edge.
   function automatic void model_edge(input logic [N-1:0] pb, input logic tick, input logic rst);
      logic [N-1:0] s, new_pressed, new_hit;
      exp_t e;
      if (rst) begin
         model_reset();
      end else begin
         s = ~raw_log[raw_log.size() - 2];
         raw_log.push_back(pb);
         s_log.push_back(s);
         new_pressed = m_pressed;
         new_hit     = m_hit;
         for (int i = 0; i < N; i++) begin
            bit all_differ;
            bit locked;
            bit set;
            // Level accepted once the last DB samples since the previous change all disagree.
            if (s_log.size() - flip_t[i] >= DB) begin
               all_differ = 1'b1;
               for (int k = 1; k <= DB; k++)
                  if (s_log[s_log.size() - k][i] == m_pressed[i]) all_differ = 1'b0;
               if (all_differ) begin
                  new_pressed[i] = ~m_pressed[i];
                  flip_t[i] = s_log.size();
               end
            end
            locked = 1'b0;
`ifdef PB_LOCKOUT_EN
            locked = consumed[i] && (ticks_after[i] < LT);
`endif
            set = m_pulse[i] && !locked;
            new_hit[i] = set | (m_hit[i] & ~tick);
            if (m_hit[i] && tick && !set) begin
               consumed[i] = 1'b1;
               ticks_after[i] = 0;
            end else if (tick && consumed[i] && ticks_after[i] < LT) begin
               ticks_after[i]++;
            end
         end
         m_pulse   = new_pressed & ~m_pressed;
         m_pressed = new_pressed;
         m_hit     = new_hit;
      end
      e.pressed = m_pressed;
      e.pulse   = m_pulse;
      e.hit     = m_hit;
      e.both    = &m_pressed;
      exp_q.push_back(e);
   endfunction

   function automatic void check(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%b expected=%b", name, mon_cyc, act, expv);
      end
   endfunction

   // Monitor: pop one expected entry per clock edge and compare.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mon_cyc++;
            check("pressed", PRESSED, e.pressed);
            check("press_pulse", PRESS_PULSE, e.pulse);
            check("hit", HIT, e.hit);
            check("both", {1'b0, BOTH}, {1'b0, e.both});
         end
      end
   end

   // Drive one cycle of inputs on the falling edge and predict its result.
   task automatic cycle(input logic [N-1:0] pb, input logic tick, input logic rst);
      @(negedge CLK);
      PB   = pb;
      TICK = tick;
      RST  = rst;
      model_edge(pb, tick, rst);
   endtask

   task automatic hold(input logic [N-1:0] pb, input int n);
      for (int k = 0; k < n; k++) cycle(pb, 1'b0, 1'b0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [N-1:0] pb_cur;
      int           hold_n[N];
      logic         last_tick;
      logic         t;
      logic         r;
      model_reset();

      // Reset state, then a reset in the middle of a debounce count.
      cycle(2'b11, 1'b0, 1'b1);
      cycle(2'b11, 1'b0, 1'b1);
      hold(2'b11, 3);
      hold(2'b10, 4);
      cycle(2'b10, 1'b0, 1'b1);
      hold(2'b10, 8);
      hold(2'b11, 8);

      // Short glitch, then a real press, release, and a late tick.
      hold(2'b10, 3);
      hold(2'b11, 6);
      hold(2'b10, 8);
      hold(2'b11, 20);
      cycle(2'b11, 1'b1, 1'b0);
      hold(2'b11, 3);

      // Button 1 press with a tick coinciding with its press pulse.
      for (int k = 0; k < 10; k++) cycle(2'b01, m_pulse[1], 1'b0);
      hold(2'b11, 8);
      cycle(2'b11, 1'b1, 1'b0);
      hold(2'b11, 3);

      // Both pressed, then button 1 released.
      hold(2'b00, 10);
      hold(2'b10, 10);
      hold(2'b11, 8);

      // Hit, consume, re-press inside and after the lockout window.
      hold(2'b10, 8);
      hold(2'b11, 6);
      cycle(2'b11, 1'b1, 1'b0);
      hold(2'b11, 2);
      hold(2'b10, 8);
      hold(2'b11, 6);
      cycle(2'b11, 1'b1, 1'b0);
      hold(2'b11, 2);
      cycle(2'b11, 1'b1, 1'b0);
      hold(2'b11, 2);
      hold(2'b10, 8);
      hold(2'b11, 6);
      cycle(2'b11, 1'b1, 1'b0);
      hold(2'b11, 3);

      // Random activity: varied hold lengths, sparse ticks, rare resets.
      pb_cur = '1;
      for (int i = 0; i < N; i++) hold_n[i] = 0;
      last_tick = 1'b0;
      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (hold_n[i] == 0) begin
               pb_cur[i] = 1'($urandom % 2);
               hold_n[i] = $urandom_range(1, 10);
            end
            hold_n[i]--;
         end
         t = 1'b0;
         if (!last_tick && (($urandom % 6) == 0 || (m_pulse != '0 && ($urandom % 2) == 0)))
            t = 1'b1;
         r = (($urandom % 400) == 0);
         cycle(pb_cur, t, r);
         last_tick = t;
      end
      hold(2'b11, 10);

      repeat (2) @(posedge CLK);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pb_conditioner.md
Name: pb_conditioner

Overview:
Input-conditioning stage directly upstream of the pong game FSM.
- Takes the raw active-low push buttons PB and synchronises and debounces them.
- Converts each press into a latched "hit request" that is held until the slow game tick consumes it, so a short press between ticks is never lost.
- Provides a debounced "all buttons pressed" level for the start and restart condition.

Parameters:
N, 2, number of push buttons
DB_CYCLES, 500_000, CLK cycles the synchronised input must hold a new level before it is accepted (10 ms at 50 MHz); minimum 2
CNT_W, 19, debounce counter width; must hold DB_CYCLES-1
LOCKOUT_TICKS, 2, game ticks of press lockout after a consumed hit (PB_LOCKOUT_EN only); minimum 1
LOCK_W, 2, lockout counter width; must hold LOCKOUT_TICKS

Ports:
CLK  input  1  system clock (50 MHz)
RST  input  1  asynchronous, active-high reset
PB  input  N  raw push buttons, active-low (0 = pressed), asynchronous to CLK
TICK  input  1  game-tick strobe, one CLK cycle wide, CLK domain
PRESSED  output  N  debounced level, active-high
PRESS_PULSE  output  N  one-CLK pulse on each debounced press (0->1 edge of PRESSED)
HIT  output  N  latched hit request, held until consumed by TICK
BOTH  output  1  1 when every PRESSED bit is 1

Behaviour:
- Reset (async, RST=1):
  - Sync flops load 1 (released).
  - Debounce counters, lockout counters, PRESSED, PRESS_PULSE and HIT clear to 0.
  - BOTH is 0.
  - Asserting RST mid-debounce or mid-lockout discards all progress.
- Synchroniser: two-flop per bit; s[i] is the second flop output, inverted so that 1 = pressed.
- Debounce, per bit, independent:
  - If s[i] == PRESSED[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments each cycle.
  - When s[i] != PRESSED[i] and cnt[i] == DB_CYCLES-1: PRESSED[i] <= s[i] and cnt[i] <= 0.
  - A glitch shorter than DB_CYCLES cycles restarts the count and never changes PRESSED.
  - Press and release are debounced identically.
- Latency: raw PB[i] falling before CLK edge k, then held, gives PRESSED[i]=1 after edge k+1+DB_CYCLES. Release latency is the same.
- PRESS_PULSE[i]:
  - Registered; 1 for exactly the cycle after PRESSED[i] goes 0->1.
  - Never asserts on release.
- HIT[i], registered:
  - Set by PRESS_PULSE[i] (gated by lockout when enabled).
  - Cleared on the edge after a cycle with TICK=1, so the consumer sees HIT during the TICK cycle.
  - PRESS_PULSE[i] and TICK in the same cycle: set wins, HIT stays 1.
  - Release of the button does not clear HIT.
  - Repeated presses while HIT=1 have no further effect (no counting).
- BOTH: combinational AND of the PRESSED bits; no extra latency.
- TICK while HIT=0: no effect on HIT.
- TICK held high for multiple cycles is illegal; behaviour is then per-cycle as specified.

Optional Feature:
Macro PB_LOCKOUT_EN (anti-mashing).
- With the macro defined:
  - Per-bit lock[i] loads LOCKOUT_TICKS on the edge where HIT[i] is cleared by TICK.
  - lock[i] decrements on each later TICK while nonzero.
  - While lock[i] != 0, PRESS_PULSE[i] still pulses but does not set HIT[i].
  - PRESSED and BOTH are unaffected.
- Without the macro: no lockout logic; every PRESS_PULSE sets HIT.

Test Plan:
1. DB_CYCLES=4; RST pulse, PB=2'b11 -> all outputs 0 and BOTH=0; assert RST mid-count -> counters restart from 0.
2. PB[0] low for 3 cycles, then high -> PRESSED, PRESS_PULSE and HIT stay 0. PB[0] held low -> PRESSED[0]=1 after edge k+5, PRESS_PULSE[0] high for exactly 1 cycle, HIT[0]=1.
3. HIT[0]=1, button released, TICK pulsed 20 cycles later -> HIT[0] still 1 during the TICK cycle, 0 on the next edge.
4. PRESS_PULSE[1] coincident with TICK -> HIT[1] remains 1 after that edge; cleared only by the following TICK.
5. Both PB held low past debounce -> BOTH=1 in the same cycle PRESSED becomes 2'b11; release PB[1] -> BOTH=0 five cycles after the release edge.
6. PB_LOCKOUT_EN, LOCKOUT_TICKS=2:
   - Hit consumed by a TICK; press again before 2 further TICKs -> PRESS_PULSE fires, HIT stays 0.
   - Press after the second TICK -> HIT=1.
